// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared widths and request/data types for the line memory arbiter
package line_mem_pkg;
  localparam int LM_DW = 8;
  localparam int LM_DEPTH = 4;
  localparam int LM_AW = 2;
  typedef struct packed {
    logic we;
    logic [LM_AW-1:0] addr;
    logic [LM_DW-1:0] wdata;
  } lm_req_t;
  typedef logic [LM_DW-1:0] lm_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among valid requesters, pointer moves only on advance
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb begin
    grant_idx = '0;
    for (int k = N; k > 0; k--)
      if (req[(int'(ptr_q) + k) % N]) grant_idx = IW'((int'(ptr_q) + k) % N);
    grant = (|req) ? N'(1) << grant_idx : '0;
    ptr_d = advance ? grant_idx : ptr_q;
  end
  always_ff @(posedge clk)
    ptr_q <= rst ? IW'(N - 1) : ptr_d;
endmodule

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin shared access to a small line memory with a single response slot
module line_mem_arbiter
  import line_mem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DEPTH = LM_DEPTH,
  parameter int DW = LM_DW,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_rdata
);
  if (NREQ < 2 || DEPTH != (1 << AW)) begin : g_bad
    $fatal(1, "line_mem_arbiter: NREQ must be >= 2 and DEPTH a power of two");
  end
  logic [DW-1:0]   mem_q [DEPTH];
  logic [NREQ-1:0] grant, rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   gi;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d, sel_wdata;
  logic [AW-1:0]   sel_addr;
  logic            sel_we, slot_free, accept;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (gi)
  );
  always_comb begin
    slot_free = !(|rsp_valid_q) || |(rsp_valid_q & rsp_ready);
    req_ready = (slot_free && !rst) ? grant : '0;
    accept = |req_ready;
    sel_we = req_we[gi];
    sel_addr = req_addr[gi*AW +: AW];
    sel_wdata = req_wdata[gi*DW +: DW];
    rsp_valid_d = accept ? req_ready : (slot_free ? '0 : rsp_valid_q);
    rsp_rdata_d = accept ? (sel_we ? sel_wdata : mem_q[sel_addr]) : rsp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept && sel_we) mem_q[sel_addr] <= sel_wdata;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule
